mux_scan_sequencer: RTL

//   Drives the S1/S0 select lines of the 4x1 MUX stage and captures its OUT.

---
 rtl/mux_seq_pkg.sv | 40 ++++
 rtl/mux_seq_dwell_cnt.sv | 33 +++
 rtl/mux_scan_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the 4x1 MUX scan sequencer.
//   state_t        : FSM states IDLE -> SCAN -> HOLD -> IDLE
//   NUM_CH, SEL_W  : channel count and select-line width
//   first_enabled  : lowest enabled channel at or above a start index
//   any_enabled    : whether such a channel exists
package mux_seq_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // Lowest channel index >= from whose enable bit is set; 0 when none.
  function automatic logic [SEL_W-1:0] first_enabled(input logic [NUM_CH-1:0] mask,
                                                     input int from);
    logic [SEL_W-1:0] idx;
    idx = '0;
    // Walking downwards leaves the lowest qualifying index in idx.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) idx = SEL_W'(i);
    end
    return idx;
  endfunction

  // True when some channel index >= from has its enable bit set.
  function automatic logic any_enabled(input logic [NUM_CH-1:0] mask,
                                       input int from);
    logic found;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i >= from && mask[i]) found = 1'b1;
    end
    return found;
  endfunction

endpackage

// File: rtl/mux_seq_dwell_cnt.sv
// Dwell counter for the scan sequencer.
// Counts cycles while en is high; tc flags the final dwell cycle
// (cnt == DWELL-1). clr (or rst) returns the count to zero and takes
// priority over en.
//   clk  in  clock
//   rst  in  synchronous active-high reset
//   clr  in  synchronous clear
//   en   in  count enable
//   tc   out terminal count (cnt == DWELL-1)
module mux_seq_dwell_cnt #(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == CNT_W'(DWELL - 1));

endmodule

// File: rtl/mux_scan_sequencer.sv
// Scan sequencer around a 4x1 MUX.
// Drives the MUX select lines through channels 0..3, holds each select for
// DWELL cycles, samples the MUX output on the last dwell cycle and presents
// the assembled 4-bit word with a valid/ready handshake.
// Optional feature: define MUXSEQ_MASK_EN to add a per-channel enable input
// (ch_en) latched at start; disabled channels are skipped and read as 0.
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a scan (sampled only in IDLE)
//   ch_en  in   [3:0] channel enables (MUXSEQ_MASK_EN builds only)
//   mux_y  in   MUX output
//   s1,s0  out  registered MUX select lines
//   data   out  [3:0] captured word, data[n] = mux_y with select n
//   valid  out  data holds a new word
//   ready  in   consumer accepts data when valid && ready
//   busy   out  scan in progress or word awaiting acceptance
module mux_scan_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL = 2,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef MUXSEQ_MASK_EN
  input  logic [NUM_CH-1:0] ch_en,
`endif
  input  logic              mux_y,
  output logic              s1,
  output logic              s0,
  output logic [NUM_CH-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy
);

  if (DWELL < 1 || DWELL >= (1 << CNT_W)) begin : g_param_err
    $error("mux_scan_sequencer: DWELL must be >= 1 and < 2**CNT_W");
  end

  state_t            state;
  logic [SEL_W-1:0]  chan;
  logic [NUM_CH-1:0] shadow;
  logic [NUM_CH-1:0] shadow_next;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] ch_en_eff;
  logic [SEL_W-1:0]  first_idx;
  logic [SEL_W-1:0]  next_idx;
  logic              next_found;
  logic              tc;
  logic              cnt_clr;
  logic              cnt_en;

`ifdef MUXSEQ_MASK_EN
  assign ch_en_eff = ch_en;
`else
  assign ch_en_eff = '1;
`endif

  // Counter runs only in SCAN and restarts after every sample so each
  // channel gets a full dwell.
  assign cnt_en  = (state == SCAN);
  assign cnt_clr = (state != SCAN) || tc;

  mux_seq_dwell_cnt #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .tc  (tc)
  );

  // NOTE: every output of this block gets a default first so no path
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    shadow_next       = shadow;
    shadow_next[chan] = mux_y;
    first_idx         = first_enabled(ch_en_eff, 0);
    next_idx          = first_enabled(mask, int'(chan) + 1);
    next_found        = any_enabled(mask, int'(chan) + 1);
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the shadow word is a few flops, not a RAM, so it is reset along
    // with the rest of the state; a reset mid-scan leaves nothing stale.
    if (rst) begin
      state    <= IDLE;
      chan     <= '0;
      shadow   <= '0;
      mask     <= '0;
      {s1, s0} <= '0;
      data     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= SCAN;
            busy     <= 1'b1;
            mask     <= ch_en_eff;
            shadow   <= '0;   // disabled channels read back as 0
            chan     <= first_idx;
            {s1, s0} <= first_idx;
          end
        end

        SCAN: begin
          if (mask == '0) begin
            // Nothing enabled: complete immediately with an all-zero word.
            data     <= '0;
            valid    <= 1'b1;
            state    <= HOLD;
            {s1, s0} <= '0;
          end else if (tc) begin
            shadow <= shadow_next;
            if (next_found) begin
              chan     <= next_idx;
              {s1, s0} <= next_idx;
            end else begin
              // Word is published in one step, including the bit just taken.
              data     <= shadow_next;
              valid    <= 1'b1;
              state    <= HOLD;
              chan     <= '0;
              {s1, s0} <= '0;
            end
          end
        end

        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
